// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction fetch stage: bus widths, reset PC,
// NOP encoding, predicted opcodes, FSM encoding and immediate decoders.
package if_stage_pkg;

    localparam int PC_W   = 64;
    localparam int INST_W = 32;

    localparam logic [PC_W-1:0]   RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
    localparam logic [INST_W-1:0] NOP_INST         = 32'h0000_0013;
    localparam logic [PC_W-1:0]   INST_BYTES       = 64'd4;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_e;

    // J-type immediate, sign-extended to the PC width
    function automatic logic [PC_W-1:0] imm_j(input logic [INST_W-1:0] instr);
        return {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

    // B-type immediate, sign-extended to the PC width
    function automatic logic [PC_W-1:0] imm_b(input logic [INST_W-1:0] instr);
        return {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/if_bpred.sv
// Static next-PC predictor: JAL and backward conditional branches are
// predicted taken, everything else (JALR included) falls through to pc+4.
module if_bpred
    import if_stage_pkg::*;
(
    input  logic [PC_W-1:0]   pc,
    input  logic [INST_W-1:0] instr,
    output logic              pre_jump,
    output logic [PC_W-1:0]   pre_branch
);

    // Decode the opcode and pick the predicted target; all adds wrap modulo 2^64
    always_comb begin
        pre_jump   = 1'b0;
        pre_branch = pc + INST_BYTES;
        case (instr[6:0])
            OPC_JAL: begin
                pre_jump   = 1'b1;
                pre_branch = pc + imm_j(instr);
            end
            OPC_BRANCH: begin
                if (instr[31]) begin
                    pre_jump   = 1'b1;
                    pre_branch = pc + imm_b(instr);
                end else begin
                    pre_jump   = 1'b0;
                    pre_branch = pc + INST_BYTES;
                end
            end
            default: begin
                pre_jump   = 1'b0;
                pre_branch = pc + INST_BYTES;
            end
        endcase
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: issues one request at a time, buffers the returned
// instruction, presents it with a static prediction and follows redirects.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic [PC_W-1:0]   redirect_pc,
    input  logic              if_ready,
    output logic              inst_req_valid,
    input  logic              inst_req_ready,
    output logic [PC_W-1:0]   inst_req_addr,
    input  logic              inst_resp_valid,
    input  logic [INST_W-1:0] inst_resp_data,
    output logic              pc_valid,
    output logic [PC_W-1:0]   IF_pc,
    output logic [INST_W-1:0] IF_instr,
    output logic              IF_pre_jump,
    output logic [PC_W-1:0]   IF_pre_branch
);

    fetch_state_e      state_r, state_s;
    logic [PC_W-1:0]   fpc_r, fpc_s;
    logic [INST_W-1:0] ibuf_r, ibuf_s;
    logic              drop_r, drop_s;
    logic              pre_jump_s;
    logic [PC_W-1:0]   pre_branch_s;

    if_bpred u_bpred (
        .pc         (fpc_r),
        .instr      (ibuf_r),
        .pre_jump   (pre_jump_s),
        .pre_branch (pre_branch_s)
    );

    // Outputs decode only registered state; flush and reset mask the packet at once
    assign inst_req_valid = (state_r == ST_REQ) && !reset;
    assign inst_req_addr  = fpc_r;
    assign pc_valid       = (state_r == ST_HOLD) && !flush && !reset;
    assign IF_pc          = fpc_r;
    assign IF_instr       = ibuf_r;
    assign IF_pre_jump    = pre_jump_s;
    assign IF_pre_branch  = pre_branch_s;

    // Next-state logic: flush outranks every other event in every state
    always_comb begin
        state_s = state_r;
        fpc_s   = fpc_r;
        ibuf_s  = ibuf_r;
        drop_s  = drop_r;
        case (state_r)
            ST_IDLE: begin
                if (flush) begin
                    fpc_s = redirect_pc;
                end else begin
                    fpc_s = fpc_r;
                end
                state_s = ST_REQ;
            end
            ST_REQ: begin
                if (flush) begin
                    fpc_s = redirect_pc;
                    if (inst_req_ready) begin
                        // Memory took the old request; its reply must be thrown away
                        drop_s  = 1'b1;
                        state_s = ST_WAIT;
                    end else begin
                        state_s = ST_REQ;
                    end
                end else if (inst_req_ready) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    fpc_s = redirect_pc;
                    if (inst_resp_valid) begin
                        drop_s  = 1'b0;
                        state_s = ST_REQ;
                    end else begin
                        drop_s  = 1'b1;
                        state_s = ST_WAIT;
                    end
                end else if (inst_resp_valid) begin
                    if (drop_r) begin
                        drop_s  = 1'b0;
                        state_s = ST_REQ;
                    end else begin
                        ibuf_s  = inst_resp_data;
                        state_s = ST_HOLD;
                    end
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (flush) begin
                    fpc_s   = redirect_pc;
                    state_s = ST_REQ;
                end else if (if_ready) begin
                    fpc_s   = pre_branch_s;
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, fetch PC, instruction buffer and drop flag registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
            fpc_r   <= RESET_PC;
            ibuf_r  <= NOP_INST;
            drop_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            fpc_r   <= fpc_s;
            ibuf_r  <= ibuf_s;
            drop_r  <= drop_s;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a transaction-level model of the fetch
// stream is compared against the DUT every cycle, with directed scenarios
// pinning literal values, followed by a randomized run.
module tb_if_stage;

    logic        clock = 1'b0;
    logic        reset, flush, if_ready;
    logic [63:0] redirect_pc;
    logic        inst_req_valid, inst_req_ready;
    logic [63:0] inst_req_addr;
    logic        inst_resp_valid;
    logic [31:0] inst_resp_data;
    logic        pc_valid, IF_pre_jump;
    logic [63:0] IF_pc, IF_pre_branch;
    logic [31:0] IF_instr;

    if_stage #(.RESET_PC(64'h0000_0000_8000_0000)) dut (
        .clock(clock), .reset(reset), .flush(flush), .redirect_pc(redirect_pc),
        .if_ready(if_ready), .inst_req_valid(inst_req_valid), .inst_req_ready(inst_req_ready),
        .inst_req_addr(inst_req_addr), .inst_resp_valid(inst_resp_valid),
        .inst_resp_data(inst_resp_data), .pc_valid(pc_valid), .IF_pc(IF_pc),
        .IF_instr(IF_instr), .IF_pre_jump(IF_pre_jump), .IF_pre_branch(IF_pre_branch)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        jump;
        logic [63:0] branch;
    } pkt_t;

    int          n_checks = 0;
    int          n_errors = 0;
    pkt_t        pkt_q[$];
    logic [63:0] acc_q[$];
    logic [31:0] mem [0:63];

    bit          rand_mode = 1'b0;
    int          lat_cur = 1;
    bit          acc_now = 1'b0;
    bit          rst_seen = 1'b1;
    logic [63:0] acc_addr_now;
    int          mem_cnt = 0;
    logic [63:0] mem_addr;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Predicted target from RISC-V rules, built with signed integer arithmetic
    function automatic logic [64:0] predict(input logic [63:0] pc, input logic [31:0] ins);
        longint off;
        logic   j;
        off = 4;
        j   = 1'b0;
        if (ins[6:0] == 7'h6F) begin
            off = ins[31] ? -1048576 : 0;
            off += longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
            j = 1'b1;
        end else if (ins[6:0] == 7'h63 && ins[31]) begin
            off = -4096 + longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
            j = 1'b1;
        end
        return {j, pc + off};
    endfunction

    // Model and per-cycle comparison, sampled on the falling edge
    initial begin
        bit          m_idle, m_req, m_out, m_stale, m_pkt, accepted, resp, exp_pv;
        logic [63:0] m_next_pc;
        logic [31:0] m_instr;
        logic [64:0] pr;
        pkt_t        p;
        m_idle = 1'b1; m_req = 1'b0; m_out = 1'b0; m_stale = 1'b0; m_pkt = 1'b0;
        m_next_pc = 64'h0000_0000_8000_0000; m_instr = 32'h13;
        forever begin
            @(negedge clock);
            if (reset) begin
                chk("reset_req_valid", inst_req_valid, 64'd0);
                chk("reset_pc_valid", pc_valid, 64'd0);
            end else begin
                chk("req_valid", inst_req_valid, 64'(m_req));
                if (m_req) chk("req_addr", inst_req_addr, m_next_pc);
                exp_pv = m_pkt && !flush;
                chk("pc_valid", pc_valid, 64'(exp_pv));
                if (exp_pv) begin
                    pr = predict(m_next_pc, m_instr);
                    chk("IF_pc", IF_pc, m_next_pc);
                    chk("IF_instr", IF_instr, 64'(m_instr));
                    chk("IF_pre_jump", IF_pre_jump, 64'(pr[64]));
                    chk("IF_pre_branch", IF_pre_branch, pr[63:0]);
                end
            end
            acc_now = inst_req_valid && inst_req_ready && !reset;
            acc_addr_now = inst_req_addr;
            rst_seen = reset;
            if (acc_now) acc_q.push_back(inst_req_addr);
            if (pc_valid === 1'b1) begin
                p.pc = IF_pc; p.instr = IF_instr; p.jump = IF_pre_jump; p.branch = IF_pre_branch;
                pkt_q.push_back(p);
            end
            if (reset) begin
                m_idle = 1'b1; m_req = 1'b0; m_out = 1'b0; m_stale = 1'b0; m_pkt = 1'b0;
                m_next_pc = 64'h0000_0000_8000_0000;
            end else begin
                accepted = m_req && inst_req_ready;
                resp = m_out && inst_resp_valid;
                if (flush) begin
                    m_next_pc = redirect_pc; m_pkt = 1'b0; m_idle = 1'b0;
                    if ((m_out && !resp) || accepted) begin
                        m_out = 1'b1; m_stale = 1'b1; m_req = 1'b0;
                    end else begin
                        m_out = 1'b0; m_req = 1'b1;
                    end
                end else if (m_idle) begin
                    m_idle = 1'b0; m_req = 1'b1;
                end else if (accepted) begin
                    m_out = 1'b1; m_stale = 1'b0; m_req = 1'b0;
                end else if (resp) begin
                    m_out = 1'b0;
                    if (m_stale) m_req = 1'b1;
                    else begin m_pkt = 1'b1; m_instr = inst_resp_data; end
                end else if (m_pkt && if_ready) begin
                    pr = predict(m_next_pc, m_instr);
                    m_pkt = 1'b0; m_next_pc = pr[63:0]; m_req = 1'b1;
                end
            end
        end
    end

    // Memory: answers each accepted request after a latency, plus stray replies
    task automatic mem_step();
        inst_resp_valid = 1'b0;
        inst_resp_data  = $urandom;
        if (rst_seen) mem_cnt = 0;
        else if (acc_now) begin
            mem_cnt  = rand_mode ? int'($urandom_range(1, 3)) : lat_cur;
            mem_addr = acc_addr_now;
        end
        if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                inst_resp_valid = 1'b1;
                inst_resp_data  = mem[mem_addr[7:2]];
            end
        end else if (rand_mode && $urandom_range(0, 9) == 0) begin
            inst_resp_valid = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        mem_step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        flush = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        acc_q.delete();
        pkt_q.delete();
    endtask

    task automatic wait_acc(input int n, input string nm);
        int k = 0;
        while (acc_q.size() < n && k < 60) begin tick(); k++; end
        chk(nm, 64'(acc_q.size() >= n), 64'd1);
    endtask

    task automatic wait_pkt(input int n, input string nm);
        int k = 0;
        while (pkt_q.size() < n && k < 60) begin tick(); k++; end
        chk(nm, 64'(pkt_q.size() >= n), 64'd1);
    endtask

    function automatic logic [63:0] acc_at(input int i);
        return (acc_q.size() > i) ? acc_q[i] : 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    task automatic check_first_pkt(input logic [63:0] pc, input logic jump, input logic [63:0] br);
        wait_pkt(1, "pkt_timeout");
        if (pkt_q.size() > 0) begin
            chk("pkt_pc", pkt_q[0].pc, pc);
            chk("pkt_jump", 64'(pkt_q[0].jump), 64'(jump));
            chk("pkt_branch", pkt_q[0].branch, br);
        end
        wait_acc(2, "acc_timeout");
        chk("next_req", acc_at(1), br);
    endtask

    task automatic redirect_after_reset(input logic [63:0] pc);
        do_reset();
        flush = 1'b1;
        redirect_pc = pc;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        logic [63:0] rp;
        int a0;
        reset = 1'b1; flush = 1'b0; redirect_pc = 64'd0; if_ready = 1'b1;
        inst_req_ready = 1'b1; inst_resp_valid = 1'b0; inst_resp_data = 32'd0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013;

        // Sequential fetch with 1-cycle memory; first request in 2nd cycle
        do_reset();
        @(negedge clock);
        chk("cycle1_no_req", inst_req_valid, 64'd0);
        @(negedge clock);
        chk("cycle2_req", inst_req_valid, 64'd1);
        chk("cycle2_addr", inst_req_addr, 64'h8000_0000);
        repeat (12) tick();
        chk("seq_req0", acc_at(0), 64'h8000_0000);
        chk("seq_req1", acc_at(1), 64'h8000_0004);
        chk("seq_req2", acc_at(2), 64'h8000_0008);

        // JAL +8
        mem[0] = 32'h0080_006F;
        do_reset();
        check_first_pkt(64'h8000_0000, 1'b1, 64'h8000_0008);
        mem[0] = 32'h0000_0013;

        // Backward and forward BEQ at 0x80000010
        mem[4] = 32'hFE00_0EE3;
        redirect_after_reset(64'h8000_0010);
        check_first_pkt(64'h8000_0010, 1'b1, 64'h8000_000C);
        mem[4] = 32'h0000_0463;
        redirect_after_reset(64'h8000_0010);
        check_first_pkt(64'h8000_0010, 1'b0, 64'h8000_0014);
        mem[4] = 32'h0000_0013;

        // PC wrap-around at the top of the address space
        redirect_after_reset(64'hFFFF_FFFF_FFFF_FFFC);
        check_first_pkt(64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0);

        // Stall in HOLD for 5 cycles
        if_ready = 1'b0;
        do_reset();
        wait_pkt(1, "stall_pkt_timeout");
        a0 = acc_q.size();
        repeat (5) tick();
        chk("stall_pkt_count", 64'(pkt_q.size()), 64'd6);
        chk("stall_req_count", 64'(a0), 64'd1);
        chk("stall_no_new_req", 64'(acc_q.size()), 64'd1);
        for (int i = 0; i < pkt_q.size(); i++) begin
            chk("stall_pc", pkt_q[i].pc, 64'h8000_0000);
            chk("stall_instr", 64'(pkt_q[i].instr), 64'h13);
        end
        if_ready = 1'b1;

        // Flush in WAIT, stale response arrives later
        lat_cur = 3;
        do_reset();
        wait_acc(1, "wait_acc_timeout");
        flush = 1'b1;
        redirect_pc = 64'h8000_1000;
        tick();
        flush = 1'b0;
        wait_acc(2, "stale_acc_timeout");
        chk("stale_no_pkt", 64'(pkt_q.size()), 64'd0);
        chk("stale_next_req", acc_at(1), 64'h8000_1000);
        lat_cur = 1;

        // Flush together with if_ready in HOLD
        if_ready = 1'b0;
        do_reset();
        wait_pkt(1, "hold_pkt_timeout");
        flush = 1'b1;
        if_ready = 1'b1;
        redirect_pc = 64'h8000_2000;
        @(negedge clock);
        chk("hold_flush_pc_valid", pc_valid, 64'd0);
        tick();
        flush = 1'b0;
        wait_acc(2, "hold_flush_acc_timeout");
        chk("hold_flush_next_req", acc_at(1), 64'h8000_2000);
        chk("hold_flush_pkts", 64'(pkt_q.size()), 64'd1);

        // Randomized traffic checked by the model
        for (int i = 0; i < 64; i++) begin
            w = $urandom;
            case ($urandom_range(0, 4))
                0: w[6:0] = 7'h6F;
                1, 2: w[6:0] = 7'h63;
                3: w[6:0] = 7'h67;
                default: w[6:0] = 7'h13;
            endcase
            mem[i] = w;
        end
        rand_mode = 1'b1;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            tick();
            reset = ($urandom_range(0, 299) == 0);
            flush = ($urandom_range(0, 11) == 0);
            rp = {$urandom, $urandom};
            rp[1:0] = 2'b00;
            if ($urandom_range(0, 3) == 0) rp[63:8] = '1;
            redirect_pc = rp;
            if_ready = ($urandom_range(0, 9) < 7);
            inst_req_ready = ($urandom_range(0, 2) != 0);
        end
        reset = 1'b0;
        flush = 1'b0;
        repeat (5) tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, 64'h0000_0000_8000_0000, address of the first fetch after reset.
REQ-002 clock  input  1  rising-edge clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 flush  input  1  redirect request from the execute stage; takes priority over every other event.
REQ-005 redirect_pc  input  64  target PC, valid while flush=1.
REQ-006 if_ready  input  1  downstream IF/ID register accepts the current instruction this cycle.
REQ-007 inst_req_valid  output  1  fetch request valid.
REQ-008 inst_req_ready  input  1  instruction memory accepts the request.
REQ-009 inst_req_addr  output  64  fetch address, equal to the fetch PC.
REQ-010 inst_resp_valid  input  1  instruction data valid.
REQ-011 inst_resp_data  input  32  fetched instruction.
REQ-012 pc_valid  output  1  IF_pc, IF_instr, IF_pre_jump and IF_pre_branch are valid.
REQ-013 IF_pc, IF_instr, IF_pre_jump, IF_pre_branch  output  64/32/1/64  the fetched packet.

Function
REQ-014 FSM states: IDLE, REQ, WAIT, HOLD; fetch PC register fpc; instruction buffer ibuf; drop flag.
REQ-015 IDLE: inst_req_valid=0; next state REQ.
REQ-016 REQ: inst_req_valid=1 and inst_req_addr=fpc; req_valid&req_ready -> WAIT.
REQ-017 While the FSM is in REQ, inst_req_addr stays stable until the request is accepted, unless flush=1.
REQ-018 WAIT: inst_resp_valid=1 -> ibuf<=inst_resp_data, state HOLD; pc_valid goes high in the following cycle (registered, with no combinational path from inst_resp to pc_valid).
REQ-019 HOLD: pc_valid=1, IF_pc=fpc, IF_instr=ibuf; if_ready=1 -> fpc<=IF_pre_branch, state REQ; if_ready=0 -> all outputs are held stable.
REQ-020 Prediction is combinational from ibuf: opcode 1101111 (JAL) -> IF_pre_jump=1 and IF_pre_branch=fpc+J-imm.
REQ-021 Opcode 1100011 with ibuf[31]=1 (backward branch) -> IF_pre_jump=1 and IF_pre_branch=fpc+B-imm.
REQ-022 All other instructions, including JALR -> IF_pre_jump=0 and IF_pre_branch=fpc+4.
REQ-023 Immediates are sign-extended to 64 bits; PC arithmetic is modulo 2^64 (wrap-around, with no overflow flag).
REQ-024 Flush forces pc_valid=0 in the same cycle, and fpc<=redirect_pc.
REQ-025 Flush in IDLE or REQ: next state REQ; an unaccepted request is abandoned and no response is expected for it.
REQ-026 Flush in REQ when req_ready=1 in the same cycle: the accepted request is treated as stale; drop<=1 and next state WAIT.
REQ-027 Flush in WAIT without inst_resp_valid: drop<=1 and the FSM stays in WAIT; the stale response is discarded, drop clears, and next state REQ.
REQ-028 Flush in WAIT with inst_resp_valid in the same cycle: the response is discarded and next state REQ.
REQ-029 Flush in HOLD: ibuf is discarded even if if_ready=1, and next state REQ.
REQ-030 Any response arriving while drop=1 is never written to ibuf.
REQ-031 Exactly one request is outstanding at a time; a response outside WAIT is ignored.

Reset
REQ-032 reset=1 -> state IDLE, fpc=RESET_PC, ibuf=32'h0000_0013 (NOP), drop=0.
REQ-033 reset=1 -> pc_valid=0 and inst_req_valid=0.
REQ-034 Reset asserted mid-transaction abandons the transaction; the first request after reset is RESET_PC, issued in the second cycle after reset deasserts.

Structure
REQ-035 The opcodes, the RESET_PC value, the PC/INST bus widths, the NOP encoding and the FSM state encodings belong in the shared defines file.
REQ-036 One sub-module, if_bpred, holds the combinational static predictor: inputs pc and instr; outputs pre_jump and pre_branch.

Verification
REQ-037 Reset release, 1-cycle memory, if_ready=1 -> requests at 0x80000000, 0x80000004, and so on; pc_valid is high one cycle after each response.
REQ-038 ibuf=0x0080006F (JAL +8) at pc 0x80000000 -> IF_pre_jump=1, IF_pre_branch=0x80000008, and the next request is 0x80000008.
REQ-039 Backward BEQ 0xFE000EE3 (-4) at pc 0x80000010 -> IF_pre_branch=0x8000000C; forward BEQ 0x00000463 (+8) -> IF_pre_jump=0 and IF_pre_branch=0x80000014.
REQ-040 HOLD with if_ready=0 for 5 cycles -> pc_valid, IF_pc and IF_instr stay stable and no new request is issued.
REQ-041 Flush with redirect_pc=0x80001000 while in WAIT, then a stale response -> the response is discarded, pc_valid stays 0, and the next request is 0x80001000.
REQ-042 Flush and if_ready asserted together in HOLD -> pc_valid=0 in that cycle and the next request is redirect_pc.
